gpio_in_ctrl: RTL and testbench

- Input-direction GPIO peripheral for the DLX on the DE2-115. It is the counterpart of the gpio_o/we_gpio output path that drives the seven-segment displays.
- Synchronizes and debounces the board switches (SW) and push-buttons (KEY[3:1]), and captures key-press events.
- Presents all of this to the processor through a registered read port at processor clock rate.

---
 rtl/gpio_in_ctrl.sv | 169 ++++++++++++++++
 tb/tb_gpio_in_ctrl.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_in_ctrl.sv
// Switch/key input port: 2-flop sync, shared-window debounce, press events.
// Build with GPIO_IN_IRQ_EN to add the registered irq output.
module gpio_in_ctrl #(
  parameter int DATA_WIDTH      = 32,
  parameter int SW_WIDTH        = 18,
  parameter int KEY_WIDTH       = 3,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SW_WIDTH-1:0]   sw_in,
  input  logic [KEY_WIDTH-1:0]  key_n_in,
  input  logic                  rd_en,
  input  logic [1:0]            addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid
`ifdef GPIO_IN_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam int W = SW_WIDTH + KEY_WIDTH;

  localparam logic [W-1:0] RST_VEC =
    {{KEY_WIDTH{1'b1}}, {SW_WIDTH{1'b0}}};

  localparam logic [CNT_WIDTH-1:0] CNT_MAX =
    CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE =
    CNT_WIDTH'(1);

  logic [W-1:0]          raw;
  logic [W-1:0]          sync1;
  logic [W-1:0]          sync2;
  logic [W-1:0]          cand;
  logic [W-1:0]          stable;
  logic [CNT_WIDTH-1:0]  cnt;
  logic [15:0]           chg_cnt;
  logic [KEY_WIDTH-1:0]  evt;

  logic                  cand_diff;
  logic                  cnt_done;
  logic                  commit;
  logic [KEY_WIDTH-1:0]  stable_k;
  logic [KEY_WIDTH-1:0]  cand_k;
  logic [KEY_WIDTH-1:0]  press;
  logic [KEY_WIDTH-1:0]  clr;

  logic [DATA_WIDTH-1:0] rd_mux;
  logic [DATA_WIDTH-1:0] rd_hold;
  logic                  rd_pend;

  assign raw = {key_n_in, sw_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= RST_VEC;
      sync2 <= RST_VEC;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_comb begin
    cand_diff = (sync2 != cand);
    cnt_done  = (cnt == CNT_MAX);
    commit    = !cand_diff && cnt_done
                && (stable != cand);
    stable_k  = stable[W-1 -: KEY_WIDTH];
    cand_k    = cand[W-1 -: KEY_WIDTH];
  end

  // One window for the whole vector: any bit moving restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand <= RST_VEC;
      cnt  <= '0;
    end else if (cand_diff) begin
      cand <= sync2;
      cnt  <= '0;
    end else if (!cnt_done) begin
      cnt  <= cnt + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable  <= RST_VEC;
      chg_cnt <= '0;
    end else if (commit) begin
      stable  <= cand;
      chg_cnt <= chg_cnt + 16'd1;
    end
  end

  // Keys are active-low: a press is a committed 1 -> 0.
  always_comb begin
    press = '0;
    if (commit) begin
      press = stable_k & ~cand_k;
    end
  end

  always_comb begin
    clr = '0;
    if (rd_en && (addr == 2'd2)) begin
      clr = evt;
    end
  end

  // Set wins over the read-clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt <= '0;
    end else begin
      evt <= (evt & ~clr) | press;
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (addr)
      2'd0: rd_mux[SW_WIDTH-1:0]  = stable[SW_WIDTH-1:0];
      2'd1: rd_mux[KEY_WIDTH-1:0] = ~stable_k;
      2'd2: rd_mux[KEY_WIDTH-1:0] = evt;
      2'd3: rd_mux[15:0]          = chg_cnt;
    endcase
  end

  // Sample on the request edge, present one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= 1'b0;
      rd_hold <= '0;
    end else begin
      rd_pend <= rd_en;
      if (rd_en) begin
        rd_hold <= rd_mux;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_pend;
      if (rd_pend) begin
        rd_data <= rd_hold;
      end
    end
  end

`ifdef GPIO_IN_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |evt;
    end
  end
`endif

endmodule

// File: tb/tb_gpio_in_ctrl.sv
// Directed bench for gpio_in_ctrl with DEBOUNCE_CYCLES=4, CNT_WIDTH=3.
// Checks latency, glitch rejection, events, collision, wrap and reset.
module tb_gpio_in_ctrl;

  logic        clk;
  logic        rst_n;
  logic [17:0] sw_in;
  logic [2:0]  key_n_in;
  logic        rd_en;
  logic [1:0]  addr;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        irq;

  int total;
  int bad;

  gpio_in_ctrl #(
    .DATA_WIDTH(32),
    .SW_WIDTH(18),
    .KEY_WIDTH(3),
    .DEBOUNCE_CYCLES(4),
    .CNT_WIDTH(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw_in(sw_in),
    .key_n_in(key_n_in),
    .rd_en(rd_en),
    .addr(addr),
    .rd_data(rd_data),
    .rd_valid(rd_valid)
`ifdef GPIO_IN_IRQ_EN
    ,
    .irq(irq)
`endif
  );

`ifndef GPIO_IN_IRQ_EN
  assign irq = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rd(input logic [1:0] a,
                    output logic [31:0] d,
                    output logic v);
    rd_en = 1'b1;
    addr  = a;
    tick();
    rd_en = 1'b0;
    tick();
    d = rd_data;
    v = rd_valid;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    sw_in    = '0;
    key_n_in = 3'b111;
    rd_en    = 1'b0;
    addr     = 2'd0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        v;
    rst_n    = 1'b0;
    sw_in    = '0;
    key_n_in = 3'b111;
    rd_en    = 1'b0;
    addr     = 2'd0;
    #12;
    total++;
    if (rd_data !== 32'h0 || rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_out got=%h/%b exp=0/0",
               rd_data, rd_valid);
    end
    rst_n = 1'b1;
    tick();
    for (int a = 0; a < 4; a++) begin
      rd(2'(a), d, v);
      total++;
      if (d !== 32'h0 || v !== 1'b1) begin
        bad++;
        $display("FAIL reset_rd%0d got=%h/%b exp=0/1",
                 a, d, v);
      end
      tick();
      total++;
      if (rd_valid !== 1'b0 || irq !== 1'b0) begin
        bad++;
        $display("FAIL reset_drop%0d got=%b/%b exp=0/0",
                 a, rd_valid, irq);
      end
    end
  endtask

  task automatic test_sw_latency();
    logic [31:0] d;
    logic        v;
    do_reset();
    sw_in = 18'h2A5A5;
    tick_n(6);
    rd_en = 1'b1;
    addr  = 2'd0;
    tick();
    tick();
    rd_en = 1'b0;
    total++;
    if (rd_data !== 32'h0 || rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL lat_edge7 got=%h/%b exp=0/1",
               rd_data, rd_valid);
    end
    tick();
    total++;
    if (rd_data !== 32'h2A5A5 || rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL lat_edge8 got=%h/%b exp=2a5a5/1",
               rd_data, rd_valid);
    end
    tick_n(2);
    total++;
    if (rd_data !== 32'h2A5A5 || rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL rd_hold got=%h/%b exp=2a5a5/0",
               rd_data, rd_valid);
    end
    rd(2'd3, d, v);
    total++;
    if (d !== 32'h1) begin
      bad++;
      $display("FAIL lat_chg got=%h exp=1", d);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    logic        v;
    do_reset();
    sw_in = 18'h1;
    tick_n(3);
    sw_in = 18'h0;
    tick_n(10);
    rd(2'd0, d, v);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL glitch_sw got=%h exp=0", d);
    end
    rd(2'd3, d, v);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL glitch_chg got=%h exp=0", d);
    end
    for (int i = 0; i < 10; i++) begin
      sw_in = (i % 2 == 0) ? 18'h2 : 18'h0;
      tick_n(2);
    end
    sw_in = 18'h2;
    tick_n(6);
    rd_en = 1'b1;
    addr  = 2'd0;
    tick();
    tick();
    rd_en = 1'b0;
    total++;
    if (rd_data !== 32'h0) begin
      bad++;
      $display("FAIL bounce_edge7 got=%h exp=0", rd_data);
    end
    tick();
    total++;
    if (rd_data !== 32'h2) begin
      bad++;
      $display("FAIL bounce_edge8 got=%h exp=2", rd_data);
    end
    rd(2'd3, d, v);
    total++;
    if (d !== 32'h1) begin
      bad++;
      $display("FAIL bounce_chg got=%h exp=1", d);
    end
  endtask

  task automatic test_key_event();
    logic [31:0] d;
    logic        v;
    do_reset();
    key_n_in = 3'b101;
    tick_n(7);
`ifdef GPIO_IN_IRQ_EN
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL irq_early got=%b exp=0", irq);
    end
`endif
    tick();
`ifdef GPIO_IN_IRQ_EN
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL irq_rise got=%b exp=1", irq);
    end
`endif
    rd(2'd1, d, v);
    total++;
    if (d !== 32'h2) begin
      bad++;
      $display("FAIL key_level got=%h exp=2", d);
    end
    tick_n(10);
    key_n_in = 3'b111;
    tick_n(10);
    rd_en = 1'b1;
    addr  = 2'd2;
    tick();
    rd_en = 1'b0;
`ifdef GPIO_IN_IRQ_EN
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL irq_hold got=%b exp=1", irq);
    end
`endif
    tick();
    total++;
    if (rd_data !== 32'h2 || rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL evt_rd got=%h/%b exp=2/1",
               rd_data, rd_valid);
    end
`ifdef GPIO_IN_IRQ_EN
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL irq_fall got=%b exp=0", irq);
    end
`endif
    rd(2'd2, d, v);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL evt_clr got=%h exp=0", d);
    end
    rd(2'd1, d, v);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL key_rel got=%h exp=0", d);
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    logic        v;
    do_reset();
    key_n_in = 3'b110;
    tick_n(10);
    key_n_in = 3'b010;
    tick_n(6);
    rd_en = 1'b1;
    addr  = 2'd2;
    tick();
    rd_en = 1'b0;
    tick();
    total++;
    if (rd_data !== 32'h1 || rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL coll_rd got=%h/%b exp=1/1",
               rd_data, rd_valid);
    end
`ifdef GPIO_IN_IRQ_EN
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL coll_irq got=%b exp=1", irq);
    end
`endif
    rd(2'd2, d, v);
    total++;
    if (d !== 32'h4) begin
      bad++;
      $display("FAIL coll_next got=%h exp=4", d);
    end
`ifdef GPIO_IN_IRQ_EN
    total++;
    if (irq !== 1'b0) begin
      bad++;
      $display("FAIL coll_irq_fall got=%b exp=0", irq);
    end
`endif
  endtask

  task automatic test_wrap_and_reset();
    logic [31:0] d;
    logic        v;
    do_reset();
    force dut.chg_cnt = 16'hFFFE;
    #1;
    release dut.chg_cnt;
    rd(2'd3, d, v);
    total++;
    if (d !== 32'hFFFE) begin
      bad++;
      $display("FAIL wrap_pre got=%h exp=fffe", d);
    end
    sw_in = 18'h1;
    tick_n(10);
    rd(2'd3, d, v);
    total++;
    if (d !== 32'hFFFF) begin
      bad++;
      $display("FAIL wrap_max got=%h exp=ffff", d);
    end
    sw_in = 18'h0;
    tick_n(10);
    rd(2'd3, d, v);
    total++;
    if (d !== 32'h0) begin
      bad++;
      $display("FAIL wrap_zero got=%h exp=0", d);
    end
    sw_in = 18'h3;
    tick_n(10);
    rd(2'd0, d, v);
    total++;
    if (d !== 32'h3 || v !== 1'b1) begin
      bad++;
      $display("FAIL pre_rst got=%h/%b exp=3/1", d, v);
    end
    sw_in = 18'h5;
    tick_n(5);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (rd_data !== 32'h0 || rd_valid !== 1'b0
        || irq !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst got=%h/%b/%b exp=0/0/0",
               rd_data, rd_valid, irq);
    end
    rst_n = 1'b1;
    tick_n(6);
    rd_en = 1'b1;
    addr  = 2'd0;
    tick();
    tick();
    rd_en = 1'b0;
    total++;
    if (rd_data !== 32'h0) begin
      bad++;
      $display("FAIL post_rst7 got=%h exp=0", rd_data);
    end
    tick();
    total++;
    if (rd_data !== 32'h5) begin
      bad++;
      $display("FAIL post_rst8 got=%h exp=5", rd_data);
    end
    rd(2'd3, d, v);
    total++;
    if (d !== 32'h1) begin
      bad++;
      $display("FAIL post_rst_chg got=%h exp=1", d);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_sw_latency();
    test_glitch();
    test_key_event();
    test_collision();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
